// File: rtl/div8.sv
// Sequential restoring unsigned divider: one quotient bit per clock, result packed as {remainder, quotient}.
// Optional macro DIV8_ZERO_FAST_EN: a zero divisor bypasses the shift-subtract loop.
module div8 #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               sig,
    input  logic               start,
    input  logic [WIDTH-1:0]   ina,
    input  logic [WIDTH-1:0]   inb,
    output logic [2*WIDTH-1:0] out,
    output logic               busy,
    output logic               done,
    output logic               dz
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t             state, state_n;
    logic [WIDTH-1:0]   q, q_n;
    logic [WIDTH-1:0]   d, d_n;
    logic [WIDTH:0]     r, r_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [2*WIDTH-1:0] out_n;
    logic               busy_n, done_n, dz_n;

    // One guard bit above R keeps the shifted remainder and its borrow in a single subtract.
    logic [WIDTH+1:0]   rs, trial;

    always_ff @(posedge clk or posedge sig) begin
        if (sig) begin
            state <= IDLE;
            q     <= '0;
            d     <= '0;
            r     <= '0;
            cnt   <= '0;
            out   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            dz    <= 1'b0;
        end else begin
            state <= state_n;
            q     <= q_n;
            d     <= d_n;
            r     <= r_n;
            cnt   <= cnt_n;
            out   <= out_n;
            busy  <= busy_n;
            done  <= done_n;
            dz    <= dz_n;
        end
    end

    always_comb begin
        state_n = state;
        q_n     = q;
        d_n     = d;
        r_n     = r;
        cnt_n   = cnt;
        out_n   = out;
        busy_n  = busy;
        done_n  = 1'b0;
        dz_n    = dz;
        rs      = {r, q[WIDTH-1]};
        trial   = rs - {2'b00, d};

        case (state)
            IDLE: begin
                if (start) begin
                    q_n     = ina;
                    d_n     = inb;
                    r_n     = '0;
                    cnt_n   = CW'(WIDTH);
                    busy_n  = 1'b1;
                    state_n = RUN;
`ifdef DIV8_ZERO_FAST_EN
                    // Preload the known divide-by-zero result so FIN packs it unchanged.
                    if (inb == '0) begin
                        q_n     = '1;
                        r_n     = {1'b0, ina};
                        cnt_n   = '0;
                        state_n = FIN;
                    end
`endif
                end
            end
            RUN: begin
                cnt_n = cnt - CW'(1);
                if (trial[WIDTH+1]) begin
                    r_n = rs[WIDTH:0];
                    q_n = {q[WIDTH-2:0], 1'b0};
                end else begin
                    r_n = trial[WIDTH:0];
                    q_n = {q[WIDTH-2:0], 1'b1};
                end
                if (cnt == CW'(1)) state_n = FIN;
            end
            FIN: begin
                out_n   = {r[WIDTH-1:0], q};
                dz_n    = (d == '0);
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_div8.sv
// Directed bench for div8: reset, basic and corner divisions, divide-by-zero, start-while-busy, abort.
module tb_div8;

    logic        clk = 1'b0;
    logic        sig;
    logic        start;
    logic [7:0]  ina, inb;
    logic [15:0] out;
    logic        busy, done, dz;

    int vectors = 0;
    int errs    = 0;
    int lat;

`ifdef DIV8_ZERO_FAST_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 9;
`endif

    div8 #(.WIDTH(8)) dut (
        .clk   (clk),
        .sig   (sig),
        .start (start),
        .ina   (ina),
        .inb   (inb),
        .out   (out),
        .busy  (busy),
        .done  (done),
        .dz    (dz)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge (E0) with the given operands.
    task automatic go(input logic [7:0] a, input logic [7:0] b);
        ina   = a;
        inb   = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Edges after E0 until done is seen; -1 if the bound expires.
    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic divide(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp_out, input logic exp_dz, input int exp_lat);
        int n;
        go(a, b);
        chk({tag, "_busy"}, busy, 1'b1);
        wait_done(n);
        chk({tag, "_lat"}, n, exp_lat);
        chk({tag, "_out"}, out, exp_out);
        chk({tag, "_dz"}, dz, exp_dz);
        chk({tag, "_busy_end"}, busy, 1'b0);
        tick();
        chk({tag, "_done_1cyc"}, done, 1'b0);
    endtask

    initial begin
        sig   = 1'b1;
        start = 1'b1;
        ina   = 8'($urandom);
        inb   = 8'($urandom);
        #1;
        chk("rst_out", out, 16'h0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_dz", dz, 1'b0);
        for (int i = 0; i < 3; i++) begin
            ina = 8'($urandom);
            inb = 8'($urandom);
            tick();
            chk("rst_hold", {out, busy, done, dz}, 19'h0);
        end
        start = 1'b0;
        sig   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_hold", {out, busy, done, dz}, 19'h0);
        end

        divide("basic", 8'd200, 8'd7, 16'h041C, 1'b0, 9);
        divide("c255_1", 8'd255, 8'd1, 16'h00FF, 1'b0, 9);
        divide("c5_9", 8'd5, 8'd9, 16'h0500, 1'b0, 9);
        divide("c0_3", 8'd0, 8'd3, 16'h0000, 1'b0, 9);
        divide("c255_255", 8'd255, 8'd255, 16'h0001, 1'b0, 9);
        divide("dz", 8'd100, 8'd0, 16'h64FF, 1'b1, ZLAT);
        divide("after_dz", 8'd17, 8'd5, 16'h0203, 1'b0, 9);

        // start re-pulsed at E4 with new operands must be ignored
        go(8'd200, 8'd7);
        tick();
        tick();
        tick();
        ina   = 8'd9;
        inb   = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        ina   = 8'd0;
        inb   = 8'd0;
        wait_done(lat);
        chk("busy_ign_lat", lat, 5);
        chk("busy_ign_out", out, 16'h041C);
        // start in the done cycle: accepted on the next edge
        ina   = 8'd9;
        inb   = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        ina   = 8'd1;
        inb   = 8'd1;
        chk("b2b_done_drop", done, 1'b0);
        chk("b2b_busy", busy, 1'b1);
        chk("b2b_out_hold", out, 16'h041C);
        wait_done(lat);
        chk("b2b_lat", lat + 1, 10);
        chk("b2b_out", out, 16'h0003);
        tick();
        chk("b2b_done_1cyc", done, 1'b0);

        // abort at E5
        go(8'd200, 8'd7);
        for (int i = 0; i < 4; i++) tick();
        sig = 1'b1;
        #1;
        chk("abort_async", {out, busy, done, dz}, 19'h0);
        tick();
        sig = 1'b0;
        begin
            int seen = 0;
            for (int i = 0; i < 15; i++) begin
                tick();
                if (done || busy) seen++;
            end
            chk("abort_quiet", seen, 0);
        end
        chk("abort_out", out, 16'h0000);
        divide("restart", 8'd200, 8'd7, 16'h041C, 1'b0, 9);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
